// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states and FIFO entry layout.
package fetch_pkg;

    localparam int unsigned INSN_BYTES = 4;
    localparam int unsigned INST_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with count-based full/empty and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    fetch_entry_t     mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/instruction_fetch.sv
// PC generator and fetch buffer feeding decode; redirects flush the buffer.
// Optional FETCH_FAULT_EN adds a sticky FAULT state for bad or out-of-range PCs.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 128,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] RESET_PC  = 32'h0,
    localparam int unsigned ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [WORD_SIZE-1:0] imem_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [WORD_SIZE-1:0] inst_data,
    output logic [31:0]          inst_pc,
    output logic                 fetch_fault
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         fetch_fault_q;

    logic         fifo_empty;
    logic         fifo_full;
    logic         push;
    logic         pop;
    logic         flush;
    logic         take_redirect;
    logic         redirect_bad;
    logic         seq_bad;
    logic [31:0]  redirect_target;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign redirect_target = redirect_pc & ~32'h3;

`ifdef FETCH_FAULT_EN
    localparam logic [31:0] PC_LIMIT = 32'(MEM_SIZE * INSN_BYTES);

    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);
    assign seq_bad      = (pc >= PC_LIMIT);
`else
    assign redirect_bad = 1'b0;
    assign seq_bad      = 1'b0;
`endif

    assign take_redirect = redirect_valid && (state != FAULT);
    // A rejected redirect leaves the buffer intact so queued entries can drain.
    assign flush = take_redirect && !redirect_bad;
    assign pop   = !fifo_empty && inst_ready;
    assign push  = (state == RUN) && !redirect_valid && !seq_bad && (!fifo_full || pop);

    assign push_entry.pc   = pc;
    assign push_entry.inst = INST_W'(imem_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            fetch_fault_q <= 1'b0;
        end else if (take_redirect) begin
            if (redirect_bad) begin
                state         <= FAULT;
                fetch_fault_q <= 1'b1;
            end else begin
                pc <= redirect_target;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (seq_bad) begin
                        state         <= FAULT;
                        fetch_fault_q <= 1'b1;
                    end else if (push) begin
                        pc <= pc + 32'(INSN_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign imem_addr   = pc[ADDR_W+1:2];
    assign inst_valid  = !fifo_empty;
    assign inst_data   = fifo_empty ? '0 : WORD_SIZE'(head_entry.inst);
    assign inst_pc     = fifo_empty ? '0 : head_entry.pc;
    assign fetch_fault = fetch_fault_q;

endmodule
